pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward controller for the 5-stage pipeline. Drives enable and flush
//  (bubble) controls for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers.
//  Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//  Selects EX-stage operand forwarding and keeps saturating stall/flush statistics.
// PARAMETERS
//  RA_W        5   register-address width
//  DM_TIMEOUT  15  max consecutive DM wait cycles before entering ERROR (>=1)
//  CNT_W       16  width of STALL_CNT / FLUSH_CNT
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      synchronous reset, active-high
//  ID_RS1/ID_RS2   in   RA_W   source regs of instruction in ID
//  EX_RS1/EX_RS2   in   RA_W   source regs of instruction in EX
//  EX_RD           in   RA_W   dest reg of instruction in EX
//  EX_MEM_READ     in   1      instruction in EX is a load
//  EX_BRANCH_TAKEN in   1      branch in EX resolved taken
//  MEM_RD          in   RA_W   dest reg in MEM;  MEM_REG_WRITE in 1 writes RF
//  WB_RD           in   RA_W   dest reg in WB;   WB_REG_WRITE  in 1 writes RF
//  MEM_DM_REQ      in   1      MEM stage accessing data memory
//  DM_ACK          in   1      data memory completes access this cycle
//  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out 1  register load enables
//  IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH           out 1  load bubble instead of data
//  FWD_A/FWD_B     out  2      00 RF, 10 from MEM (ALU_RES), 01 from WB
//  DM_TIMEOUT_ERR  out  1      sticky error flag
//  STALL_CNT/FLUSH_CNT out CNT_W  saturating statistics
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=RUN, wait cnt=0, DM_TIMEOUT_ERR=0, both counters=0.
//   While rst high: all *_EN=0, all *_FLUSH=1, FWD_A/B=00.
//  States: RUN, MEM_WAIT, ERROR (registered). Controls are combinational, same cycle (0 lat).
//  mem_stall = MEM_DM_REQ & ~DM_ACK. lu = EX_MEM_READ & EX_RD!=0 & (EX_RD==ID_RS1|EX_RD==ID_RS2).
//  Priority in RUN/MEM_WAIT: mem_stall > EX_BRANCH_TAKEN > lu > normal.
//   normal: all EN=1, all FLUSH=0.
//   mem_stall: PC/IF_ID/ID_EX/EX_MEM EN=0; MEM_WB_EN=1, MEM_WB_FLUSH=1; other FLUSH=0.
//   branch: all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1 (PC loads target). lu ignored.
//   lu: PC_EN=0, IF_ID_EN=0, ID_EX_EN=1 with ID_EX_FLUSH=1; EX_MEM/MEM_WB EN=1.
//  FSM: RUN->MEM_WAIT on mem_stall (wait cnt:=1). MEM_WAIT: mem_stall -> cnt+1;
//   DM_ACK or ~MEM_DM_REQ -> RUN, cnt:=0. When mem_stall and cnt==DM_TIMEOUT -> ERROR.
//   Ack on the same cycle as timeout boundary wins (returns to RUN, no error).
//  ERROR: all EN=0, FLUSH=0, DM_TIMEOUT_ERR=1; exits only via rst.
//  Forwarding (valid in every state except rst): FWD_A=10 if MEM_REG_WRITE & MEM_RD!=0 &
//   MEM_RD==EX_RS1; else 01 if WB_REG_WRITE & WB_RD!=0 & WB_RD==EX_RS1; else 00. FWD_B same w/ EX_RS2.
//   MEM has priority over WB when both match.
//  STALL_CNT +1 each cycle PC_EN=0 outside rst/ERROR; FLUSH_CNT +1 per branch-flush cycle.
//   Both saturate at 2^CNT_W-1 (no wrap).
// TESTING
//  1 EX_MEM_READ=1,EX_RD=3,ID_RS2=3 -> 1 cycle PC_EN=0,IF_ID_EN=0,ID_EX_FLUSH=1; STALL_CNT=1.
//  2 EX_BRANCH_TAKEN=1 with lu true -> IF_ID_FLUSH=ID_EX_FLUSH=1,PC_EN=1; FLUSH_CNT=1.
//  3 MEM_DM_REQ=1, DM_ACK after 4 cycles -> 4 cycles EX_MEM_EN=0,MEM_WB_FLUSH=1; back to RUN.
//  4 MEM_DM_REQ=1, DM_ACK never -> ERROR after 15 stall cycles, ERR=1; rst clears it.
//  5 MEM_RD=WB_RD=EX_RS1=7, both write -> FWD_A=10; EX_RS1=0 -> FWD_A=00.
//  6 CNT_W=4, 20 lu stalls -> STALL_CNT holds 15; rst mid-MEM_WAIT -> RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait handling, EX operand forwarding and saturating hazard statistics.
module pipeline_hazard_ctrl #(
    parameter int RA_W       = 5,
    parameter int DM_TIMEOUT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ID_RS1,
    input  logic [RA_W-1:0]  ID_RS2,
    input  logic [RA_W-1:0]  EX_RS1,
    input  logic [RA_W-1:0]  EX_RS2,
    input  logic [RA_W-1:0]  EX_RD,
    input  logic             EX_MEM_READ,
    input  logic             EX_BRANCH_TAKEN,
    input  logic [RA_W-1:0]  MEM_RD,
    input  logic             MEM_REG_WRITE,
    input  logic [RA_W-1:0]  WB_RD,
    input  logic             WB_REG_WRITE,
    input  logic             MEM_DM_REQ,
    input  logic             DM_ACK,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             MEM_WB_FLUSH,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             DM_TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    localparam int WC_W = $clog2(DM_TIMEOUT + 1);

    logic [1:0]      state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_stall;
    logic            load_use;
    logic            branch_flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    assign mem_stall = MEM_DM_REQ & ~DM_ACK;
    assign load_use  = EX_MEM_READ & (EX_RD != '0) & ((EX_RD == ID_RS1) | (EX_RD == ID_RS2));
    assign branch_flush = ~rst & (state != S_ERROR) & ~mem_stall & EX_BRANCH_TAKEN;

    always_comb begin
        fwd_a = 2'b00;
        if (MEM_REG_WRITE && MEM_RD != '0 && MEM_RD == EX_RS1)
            fwd_a = 2'b10;
        else if (WB_REG_WRITE && WB_RD != '0 && WB_RD == EX_RS1)
            fwd_a = 2'b01;

        fwd_b = 2'b00;
        if (MEM_REG_WRITE && MEM_RD != '0 && MEM_RD == EX_RS2)
            fwd_b = 2'b10;
        else if (WB_REG_WRITE && WB_RD != '0 && WB_RD == EX_RS2)
            fwd_b = 2'b01;
    end

    always_comb begin
        PC_EN        = 1'b1;
        IF_ID_EN     = 1'b1;
        ID_EX_EN     = 1'b1;
        EX_MEM_EN    = 1'b1;
        MEM_WB_EN    = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        MEM_WB_FLUSH = 1'b0;
        FWD_A        = fwd_a;
        FWD_B        = fwd_b;
        if (rst) begin
            PC_EN        = 1'b0;
            IF_ID_EN     = 1'b0;
            ID_EX_EN     = 1'b0;
            EX_MEM_EN    = 1'b0;
            MEM_WB_EN    = 1'b0;
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            MEM_WB_FLUSH = 1'b1;
            FWD_A        = 2'b00;
            FWD_B        = 2'b00;
        end else if (state == S_ERROR) begin
            PC_EN     = 1'b0;
            IF_ID_EN  = 1'b0;
            ID_EX_EN  = 1'b0;
            EX_MEM_EN = 1'b0;
            MEM_WB_EN = 1'b0;
        end else if (mem_stall) begin
            // Freeze everything upstream of MEM; WB receives a bubble.
            PC_EN        = 1'b0;
            IF_ID_EN     = 1'b0;
            ID_EX_EN     = 1'b0;
            EX_MEM_EN    = 1'b0;
            MEM_WB_FLUSH = 1'b1;
        end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (load_use) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_FLUSH = 1'b1;
        end
    end

    assign DM_TIMEOUT_ERR = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_stall) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    // An ack on the boundary cycle clears mem_stall, so it returns to RUN.
                    if (!mem_stall) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(DM_TIMEOUT)) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_ERROR: state <= S_ERROR;
                default: begin
                    state    <= S_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (state != S_ERROR && !PC_EN && STALL_CNT != '1)
                STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (branch_flush && FLUSH_CNT != '1)
                FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
    end

endmodule
